// File: rtl/systolic_skew_feeder.sv
// Buffers key/query vectors and replays them as a diagonally skewed stream
// into the PE cluster, then waits for the cluster to drain before finishing.
module systolic_skew_feeder #(
    parameter int ROWS   = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     start,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_act,
    input  logic [DATA_W-1:0]        wr_wgt,
    input  logic                     cluster_done,
    output logic [ROWS*DATA_W-1:0]   activations,
    output logic [ROWS*DATA_W-1:0]   weights,
    output logic [ROWS-1:0]          done,
    output logic                     busy,
    output logic                     finished
);

    localparam int ENTRIES = ROWS * DEPTH;
    localparam int CNT_W   = $clog2(ROWS + DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS + DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_act_mem [ENTRIES];
    logic [DATA_W-1:0]      r_wgt_mem [ENTRIES];
    logic [ROWS*DATA_W-1:0] r_act;
    logic [ROWS*DATA_W-1:0] r_wgt;
    logic [ROWS-1:0]        r_done;
    logic                   r_busy;
    logic                   r_fin;

    logic                   w_launch;
    logic                   w_wr;
    logic                   w_last;
    logic                   w_release;
    logic [ROWS*DATA_W-1:0] w_act_nxt;
    logic [ROWS*DATA_W-1:0] w_wgt_nxt;
    logic [ROWS-1:0]        w_done_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (en) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_STREAM;
            S_STREAM: if (r_cnt == LAST) w_state_nxt = S_WAIT;
            S_WAIT:   if (cluster_done) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_launch  = en && (r_state == S_IDLE) && start;
        w_wr      = rst_n && en && (r_state == S_IDLE) && wr_en
                    && (int'(wr_addr) < ENTRIES);
        w_last    = (r_state == S_STREAM) && (r_cnt == LAST);
        w_release = (r_state == S_WAIT) && cluster_done;
    end

    // Lane r lags lane 0 by r edges; element index is (n-1-r).
    always_comb begin
        w_act_nxt  = '0;
        w_wgt_nxt  = '0;
        w_done_set = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(r_cnt) > r && int'(r_cnt) <= r + DEPTH) begin
                w_act_nxt[r*DATA_W +: DATA_W] =
                    r_act_mem[ADDR_W'(r*DEPTH + int'(r_cnt) - 1 - r)];
                w_wgt_nxt[r*DATA_W +: DATA_W] =
                    r_wgt_mem[ADDR_W'(r*DEPTH + int'(r_cnt) - 1 - r)];
            end
            if (int'(r_cnt) == r + DEPTH + 1) begin
                w_done_set[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_act_mem[wr_addr] <= wr_act;
            r_wgt_mem[wr_addr] <= wr_wgt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_act  <= '0;
            r_wgt  <= '0;
            r_done <= '0;
            r_busy <= 1'b0;
            r_fin  <= 1'b0;
            r_cnt  <= '0;
        end else if (en) begin
            r_fin <= 1'b0;
            if (w_launch) begin
                r_busy <= 1'b1;
                r_done <= '0;
                r_cnt  <= CNT_W'(1);
            end
            if (r_state == S_STREAM) begin
                r_act  <= w_act_nxt;
                r_wgt  <= w_wgt_nxt;
                r_done <= r_done | w_done_set;
                if (!w_last) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_release) begin
                r_busy <= 1'b0;
                r_fin  <= 1'b1;
            end
        end
    end

    assign activations = r_act;
    assign weights     = r_wgt;
    assign done        = r_done;
    assign busy        = r_busy;
    assign finished    = r_fin;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: expected skewed lanes are
// queued at launch and popped edge by edge as the stream comes out.
module tb_systolic_skew_feeder;

    localparam int ROWS   = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int N      = ROWS * DEPTH;
    localparam int RUN    = ROWS + DEPTH;
    localparam int LW     = ROWS * DATA_W;

    typedef struct {
        logic [LW-1:0]   act;
        logic [LW-1:0]   wgt;
        logic [ROWS-1:0] done;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              start;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_act;
    logic [DATA_W-1:0] wr_wgt;
    logic              cluster_done;
    logic [LW-1:0]     activations;
    logic [LW-1:0]     weights;
    logic [ROWS-1:0]   done;
    logic              busy;
    logic              finished;

    logic [DATA_W-1:0] m_act [N];
    logic [DATA_W-1:0] m_wgt [N];
    exp_t              q [$];
    int                n_chk = 0;
    int                n_err = 0;

    systolic_skew_feeder #(
        .ROWS(ROWS), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_act(wr_act),
        .wr_wgt(wr_wgt), .cluster_done(cluster_done),
        .activations(activations), .weights(weights),
        .done(done), .busy(busy), .finished(finished)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] lane(input logic [LW-1:0] v,
                                              input int r);
        return v[r*DATA_W +: DATA_W];
    endfunction

    task automatic push_run();
        exp_t e;
        for (int n = 1; n <= RUN; n++) begin
            e.act  = '0;
            e.wgt  = '0;
            e.done = '0;
            for (int r = 0; r < ROWS; r++) begin
                int k = n - 1 - r;
                if (k >= 0 && k < DEPTH) begin
                    e.act[r*DATA_W +: DATA_W] = m_act[r*DEPTH + k];
                    e.wgt[r*DATA_W +: DATA_W] = m_wgt[r*DEPTH + k];
                end
                if (n >= r + DEPTH + 1) e.done[r] = 1'b1;
            end
            q.push_back(e);
        end
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("launch_busy", LW'(busy), LW'(1'b1));
        chk("launch_done", LW'(done), '0);
        push_run();
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, "_act"}, activations, e.act);
        chk({tag, "_wgt"}, weights, e.wgt);
        chk({tag, "_done"}, LW'(done), LW'(e.done));
        chk({tag, "_busy"}, LW'(busy), LW'(1'b1));
    endtask

    // stall_at: drop en for 3 cycles after that edge; poke_at: illegal
    // start/write sampled on the following edge; stop_at: leave early.
    task automatic stream(input int stall_at, input int poke_at,
                          input int stop_at);
        exp_t e;
        for (int n = 1; n <= RUN; n++) begin
            step();
            start = 1'b0;
            wr_en = 1'b0;
            if (q.size() == 0) begin
                chk("queue_empty", LW'(1), LW'(0));
                return;
            end
            e = q.pop_front();
            cmp_out("stream", e);
            if (n == 1) chk("e1_l0", LW'(lane(activations, 0)), LW'(16'h0001));
            if (n == 2) chk("e2_l1", LW'(lane(activations, 1)), LW'(16'h0005));
            if (n == 8) begin
                chk("e8_l7a", LW'(lane(activations, 7)), LW'(16'h001D));
                chk("e8_l7w", LW'(lane(weights, 7)), LW'(16'h011C));
            end
            if (n == stall_at) begin
                en = 1'b0;
                repeat (3) begin
                    step();
                    cmp_out("hold", e);
                end
                en = 1'b1;
            end
            if (n == poke_at) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_act  = 16'hBEEF;
                wr_wgt  = 16'hBEEF;
            end
            if (n == stop_at) return;
        end
    endtask

    task automatic wait_release(input bit with_start);
        repeat (2) begin
            step();
            chk("wait_busy", LW'(busy), LW'(1'b1));
            chk("wait_act", activations, '0);
            chk("wait_done", LW'(done), LW'({ROWS{1'b1}}));
        end
        cluster_done = 1'b1;
        start        = with_start;
        step();
        cluster_done = 1'b0;
        chk("fin_pulse", LW'(finished), LW'(1'b1));
        chk("fin_busy", LW'(busy), LW'(1'b0));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; start = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_act = '0; wr_wgt = '0; cluster_done = 1'b0;
        step();
        step();
        chk("rst_act", activations, '0);
        chk("rst_wgt", weights, '0);
        chk("rst_done", LW'(done), '0);
        chk("rst_busy", LW'(busy), '0);
        chk("rst_fin", LW'(finished), '0);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_act  = DATA_W'(i + 1);
            wr_wgt  = DATA_W'(16'h100 + i);
            m_act[i] = wr_act;
            m_wgt[i] = wr_wgt;
            step();
        end
        wr_en = 1'b0;

        // basic run, cluster_done ignored while streaming
        cluster_done = 1'b1;
        launch();
        cluster_done = 1'b0;
        stream(0, 0, 0);
        wait_release(1'b0);
        step();
        chk("fin_clear", LW'(finished), '0);
        chk("idle_busy", LW'(busy), '0);

        // enable stall
        launch();
        stream(3, 0, 0);
        wait_release(1'b0);
        step();

        // start/write while busy are ignored
        launch();
        stream(0, 2, 0);
        wait_release(1'b0);
        step();
        launch();
        stream(0, 0, 0);
        wait_release(1'b0);
        step();

        // reset mid-stream at edge 6
        launch();
        stream(0, 0, 5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_act", activations, '0);
        chk("mrst_done", LW'(done), '0);
        chk("mrst_busy", LW'(busy), '0);
        q.delete();
        step();
        chk("mrst_idle", LW'(busy), '0);
        launch();
        stream(0, 0, 0);

        // release and start together: no launch, next start works
        wait_release(1'b1);
        chk("nolaunch_done", LW'(done), LW'({ROWS{1'b1}}));
        launch();
        chk("relaunch_fin", LW'(finished), '0);
        stream(0, 0, 0);
        wait_release(1'b0);
        step();
        chk("end_fin", LW'(finished), '0);
        chk("end_q", LW'(q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
